// File: rtl/module_branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: counter encoding, entry layout
// and the 2-bit saturating counter update.
package pkg_btb;

    // Entry fields are sized for this width; the BTB's XLEN must not exceed it.
    localparam int BTB_XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                valid;
        logic [BTB_XLEN-1:0] tag;
        logic [BTB_XLEN-1:0] target;
        ctr_t                ctr;
    } btb_entry_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t next;
        unique case (ctr)
            SNT:     next = taken ? WNT : SNT;
            WNT:     next = taken ? WT  : SNT;
            WT:      next = taken ? ST  : WNT;
            default: next = taken ? ST  : WT;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/module_branch_target_buffer_sat_counter2.sv
// Pure next-state function of a 2-bit saturating direction counter.
// Kept as its own module so a branch history table can share it.
module module_sat_counter2
    import pkg_btb::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    assign o_ctr = sat_update(ctr_t'(i_ctr), i_taken);

endmodule

// File: rtl/module_branch_target_buffer.sv
// Direct-mapped BTB with per-entry 2-bit direction counter; combinational
// lookup for Fetch, trained from Execute. Optional counters: BTB_PERF_EN.
module module_branch_target_buffer
    import pkg_btb::*;
#(
    parameter int ENTRIES = 16,
    parameter int XLEN    = BTB_XLEN
)
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pcF_i,
    output logic            predTakenF_o,
    output logic [XLEN-1:0] predTargetF_o,
    input  logic            we_btb_i,
    input  logic [XLEN-1:0] pcE_i,
    input  logic            takenE_i,
    input  logic [XLEN-1:0] targetE_i,
    output logic            hitE_o
`ifdef BTB_PERF_EN
    ,
    output logic [31:0]     lookups_o,
    output logic [31:0]     updates_o,
    output logic [31:0]     mispred_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t          r_mem [ENTRIES];
    logic                r_hitE;

    logic [IDX_W-1:0]    w_idxF;
    logic [IDX_W-1:0]    w_idxE;
    logic [BTB_XLEN-1:0] w_tagF;
    logic [BTB_XLEN-1:0] w_tagE;
    btb_entry_t          w_entF;
    btb_entry_t          w_entE;
    logic                w_hitF;
    logic                w_hitE;
    logic [1:0]          w_ctr_nextE;
    logic                w_unused;

    // Byte-offset bits never select an entry.
    assign w_unused = &{1'b0, pcF_i[1:0], pcE_i[1:0]};

    assign w_idxF = pcF_i[IDX_W+1:2];
    assign w_idxE = pcE_i[IDX_W+1:2];
    assign w_tagF = BTB_XLEN'(pcF_i[XLEN-1:IDX_W+2]);
    assign w_tagE = BTB_XLEN'(pcE_i[XLEN-1:IDX_W+2]);

    assign w_entF = r_mem[w_idxF];
    assign w_entE = r_mem[w_idxE];
    assign w_hitF = w_entF.valid & (w_entF.tag == w_tagF);
    assign w_hitE = w_entE.valid & (w_entE.tag == w_tagE);

    // Lookup reads the registered array only, so an update in the same cycle is not seen.
    assign predTakenF_o  = w_hitF & w_entF.ctr[1];
    assign predTargetF_o = predTakenF_o ? XLEN'(w_entF.target) : '0;
    assign hitE_o        = r_hitE;

    module_sat_counter2 u_sat_counter2 (
        .i_ctr   (w_entE.ctr),
        .i_taken (takenE_i),
        .o_ctr   (w_ctr_nextE)
    );

    // NOTE: the array is flops, not RAM: valid bits and counters must clear on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
            r_hitE <= 1'b0;
        end else begin
            r_hitE <= we_btb_i & w_hitE;
            if (we_btb_i) begin
                if (w_hitE) begin
                    r_mem[w_idxE].ctr <= ctr_t'(w_ctr_nextE);
                    if (takenE_i) begin
                        r_mem[w_idxE].target <= BTB_XLEN'(targetE_i);
                    end
                end else if (takenE_i) begin
                    // Taken miss allocates, evicting any alias at this index.
                    r_mem[w_idxE] <= '{valid: 1'b1, tag: w_tagE,
                                       target: BTB_XLEN'(targetE_i), ctr: CTR_ALLOC};
                end
            end
        end
    end

`ifdef BTB_PERF_EN
    logic [31:0] r_lookups;
    logic [31:0] r_updates;
    logic [31:0] r_mispred;
    logic        w_predE;
    logic        w_mispredE;

    assign w_predE    = w_hitE & w_entE.ctr[1];
    assign w_mispredE = (w_predE != takenE_i) |
                        (w_predE & takenE_i & (w_entE.target != BTB_XLEN'(targetE_i)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lookups <= '0;
            r_updates <= '0;
            r_mispred <= '0;
        end else begin
            r_lookups <= r_lookups + 32'd1;
            if (we_btb_i) begin
                r_updates <= r_updates + 32'd1;
                if (w_mispredE) begin
                    r_mispred <= r_mispred + 32'd1;
                end
            end
        end
    end

    assign lookups_o = r_lookups;
    assign updates_o = r_updates;
    assign mispred_o = r_mispred;
`endif

endmodule

// File: tb/tb_module_branch_target_buffer.sv
// Directed self-checking bench for module_branch_target_buffer (ENTRIES=16).
// Perf-counter checks compile in only when BTB_PERF_EN is defined.
module tb_module_branch_target_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        we;
    logic [31:0] pcE;
    logic        takenE;
    logic [31:0] targetE;
    logic        hitE;
`ifdef BTB_PERF_EN
    logic [31:0] lookups;
    logic [31:0] updates;
    logic [31:0] mispred;
`endif

    int n_checks = 0;
    int n_errors = 0;

    module_branch_target_buffer #(.ENTRIES(16), .XLEN(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pcF_i         (pcF),
        .predTakenF_o  (predTaken),
        .predTargetF_o (predTarget),
        .we_btb_i      (we),
        .pcE_i         (pcE),
        .takenE_i      (takenE),
        .targetE_i     (targetE),
        .hitE_o        (hitE)
`ifdef BTB_PERF_EN
        ,
        .lookups_o     (lookups),
        .updates_o     (updates),
        .mispred_o     (mispred)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One update cycle; returns 1 time unit after the training edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        @(negedge clk);
        we      = 1'b1;
        pcE     = pc;
        takenE  = tk;
        targetE = tgt;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
        pcF = pc;
        #1;
        check({tag, ".taken"}, {31'd0, predTaken}, {31'd0, exp_taken});
        check({tag, ".target"}, predTarget, exp_tgt);
    endtask

    initial begin
        rst     = 1'b1;
        we      = 1'b0;
        pcE     = '0;
        takenE  = 1'b0;
        targetE = '0;
        pcF     = 32'h40;
        #2;
        check("rst.taken",  {31'd0, predTaken}, 32'd0);
        check("rst.target", predTarget, 32'd0);
        check("rst.hitE",   {31'd0, hitE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Allocate 0x40; same-cycle lookup must still miss.
        @(negedge clk);
        we = 1'b1; pcE = 32'h40; takenE = 1'b1; targetE = 32'h100;
        pcF = 32'h40;
        #1;
        check("nobypass.taken", {31'd0, predTaken}, 32'd0);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("alloc.hitE", {31'd0, hitE}, 32'd0);
        look("alloc", 32'h40, 1'b1, 32'h100);

        // Counter walk: 10 -> 01 -> 00 -> 01 -> 10.
        upd(32'h40, 1'b0, 32'h0);
        check("nt1.hitE", {31'd0, hitE}, 32'd1);
        look("nt1", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b0, 32'h0);
        look("nt2", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100);
        look("t1", 32'h40, 1'b0, 32'h0);
        upd(32'h40, 1'b1, 32'h100);
        look("t2", 32'h40, 1'b1, 32'h100);
        @(posedge clk);
        #1;
        check("idle.hitE", {31'd0, hitE}, 32'd0);

        // Alias at the same index evicts on a taken miss only.
        upd(32'h440, 1'b1, 32'h200);
        check("alias.hitE", {31'd0, hitE}, 32'd0);
        look("alias.old", 32'h40, 1'b0, 32'h0);
        look("alias.new", 32'h440, 1'b1, 32'h200);
        upd(32'h840, 1'b0, 32'h999);
        check("ntmiss.hitE", {31'd0, hitE}, 32'd0);
        look("ntmiss.keep", 32'h440, 1'b1, 32'h200);
        look("ntmiss.noalloc", 32'h840, 1'b0, 32'h0);

        // Saturation: 10 + 5 taken = 11; NT -> 10 (taken); NT -> 01 (not taken).
        for (int i = 0; i < 5; i++) upd(32'h440, 1'b1, 32'h200);
        upd(32'h440, 1'b0, 32'h0);
        look("sat.nt1", 32'h440, 1'b1, 32'h200);
        upd(32'h440, 1'b0, 32'h0);
        look("sat.nt2", 32'h440, 1'b0, 32'h0);
        upd(32'h440, 1'b1, 32'h300);
        look("hit.retarget", 32'h440, 1'b1, 32'h300);

        // Write enable low: garbage on the E inputs must not change anything.
        @(negedge clk);
        pcE = 32'h440; takenE = 1'b0; targetE = 32'hdead;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("we0.hitE", {31'd0, hitE}, 32'd0);
        look("we0.keep", 32'h440, 1'b1, 32'h300);

        // Second index; low PC bits do not affect the lookup.
        upd(32'h104, 1'b1, 32'h500);
        look("idx1", 32'h104, 1'b1, 32'h500);
        look("idx1.lowbits", 32'h106, 1'b1, 32'h500);

        // Asynchronous reset mid-cycle after a hit update.
        upd(32'h440, 1'b1, 32'h300);
        check("prerst.hitE", {31'd0, hitE}, 32'd1);
        pcF = 32'h440;
        #2;
        rst = 1'b1;
        #1;
        check("arst.taken",  {31'd0, predTaken}, 32'd0);
        check("arst.target", predTarget, 32'd0);
        check("arst.hitE",   {31'd0, hitE}, 32'd0);

        // An update presented while reset is held is discarded.
        @(negedge clk);
        we = 1'b1; pcE = 32'h40; takenE = 1'b1; targetE = 32'h100;
        @(posedge clk);
        #1;
        we  = 1'b0;
        rst = 1'b0;
        check("postrst.hitE", {31'd0, hitE}, 32'd0);
`ifdef BTB_PERF_EN
        check("perf.lookups", lookups, 32'd0);
        check("perf.updates", updates, 32'd0);
        check("perf.mispred", mispred, 32'd0);
`endif
        look("postrst.40",  32'h40,  1'b0, 32'h0);
        look("postrst.104", 32'h104, 1'b0, 32'h0);
        look("postrst.440", 32'h440, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
